// File: rtl/delay_sched_pkg.sv
// Shared types and defaults for the delay scheduler: FSM state encoding, default widths,
// and the effective-length rule (a requested length of 0 selects the default delay).
package delay_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_e;

  localparam int unsigned DefCntW         = 9;
  localparam int unsigned DefDefaultDelay = 500;

  function automatic logic [31:0] eff_len(input logic [31:0] len, input logic [31:0] dflt);
    return (len == '0) ? dflt : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr_i,
// wrapping modulo N_REQ. Returns both the one-hot grant and its binary index.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  logic        found;
  int unsigned j;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = (32'(ptr_i) + i) % N_REQ;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// One down-counting delay timer shared round-robin among N_REQ requesters.
// Optional abort input enabled by defining DELAY_SCHED_CANCEL_EN.
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned CNT_W         = DefCntW,
  parameter int unsigned DEFAULT_DELAY = DefDefaultDelay
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CNT_W-1:0] delay_len_i,
`ifdef DELAY_SCHED_CANCEL_EN
  input  logic                   cancel_i,
`endif
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic [CNT_W-1:0]  sel_len;
  logic [IdxW-1:0]   ptr_next;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_idx_o(arb_idx)
  );

  assign sel_len  = delay_len_i[int'(arb_idx) * CNT_W +: CNT_W];
  // Owner goes to the back of the queue once its service ends.
  assign ptr_next = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    done_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          grant_d = arb_gnt;
          idx_d   = arb_idx;
          cnt_d   = CNT_W'(eff_len(32'(sel_len), 32'(DEFAULT_DELAY)));
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end
`ifdef DELAY_SCHED_CANCEL_EN
        if (cancel_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          grant_d = '0;
          done_d  = '0;
          ptr_d   = ptr_next;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = ptr_next;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_delay_scheduler.sv
// Directed self-checking bench for delay_scheduler; exercises the cancel path
// only when DELAY_SCHED_CANCEL_EN is defined.
module tb_delay_scheduler;

  localparam int unsigned NReq = 4;
  localparam int unsigned CntW = 9;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NReq-1:0]     req_i;
  logic [NReq-1:0][CntW-1:0] dl;
  logic [NReq-1:0]     grant_o;
  logic [NReq-1:0]     done_o;
  logic                busy_o;
`ifdef DELAY_SCHED_CANCEL_EN
  logic                cancel_i;
`endif

  int n_checks = 0;
  int n_errors = 0;

  delay_scheduler #(
    .N_REQ        (NReq),
    .CNT_W        (CntW),
    .DEFAULT_DELAY(500)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .delay_len_i(dl),
`ifdef DELAY_SCHED_CANCEL_EN
    .cancel_i   (cancel_i),
`endif
    .grant_o    (grant_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    #1;
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // Next edge is the grant edge E0; follows the delay through done and the idle cycle.
  task automatic expect_grant(input int idx, input int len, input bit drop);
    logic [31:0] oh;
    oh = 32'(1) << idx;
    tick();
    check("grant_start", 32'(grant_o), oh);
    check("busy_start", 32'(busy_o), 32'h1);
    for (int k = 1; k <= len; k++) begin
      tick();
      check("grant_hold", 32'(grant_o), oh);
      check("done_pulse", 32'(done_o), (k == len) ? oh : 32'h0);
    end
    if (drop) req_i = '0;
    tick();
    check("grant_clear", 32'(grant_o), 32'h0);
    check("busy_clear", 32'(busy_o), 32'h0);
    check("done_clear", 32'(done_o), 32'h0);
  endtask

  initial begin
    req_i  = '0;
    dl     = '0;
    rst_ni = 1'b1;
`ifdef DELAY_SCHED_CANCEL_EN
    cancel_i = 1'b0;
`endif
    #2;
    apply_reset();
    tick();
    check("idle_busy", 32'(busy_o), 32'h0);

    // Single request, length 5
    dl[0] = 9'd5;
    req_i = 4'b0001;
    expect_grant(0, 5, 1'b1);
    check("no_regrant", 32'(grant_o), 32'h0);

    // Zero length selects the default of 500
    dl[1] = 9'd0;
    req_i = 4'b0010;
    expect_grant(1, 500, 1'b1);

    // Round robin from pointer 0, all lengths 3, grants every 5 cycles
    apply_reset();
    dl    = {9'd3, 9'd3, 9'd3, 9'd3};
    req_i = 4'b1111;
    expect_grant(0, 3, 1'b0);
    expect_grant(1, 3, 1'b0);
    expect_grant(2, 3, 1'b0);
    expect_grant(3, 3, 1'b0);
    expect_grant(0, 3, 1'b1);

    // Mid-count reset: outputs clear asynchronously, no done, regrant requester 0
    apply_reset();
    dl[0] = 9'd10;
    req_i = 4'b0001;
    tick();
    check("mid_grant", 32'(grant_o), 32'h1);
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant_o), 32'h0);
    check("mid_rst_busy", 32'(busy_o), 32'h0);
    check("mid_rst_done", 32'(done_o), 32'h0);
    tick();
    check("mid_rst_hold", 32'(done_o), 32'h0);
    rst_ni = 1'b1;
    expect_grant(0, 10, 1'b1);

    // Length change and request drop during COUNT (pointer is now 1)
    dl[0] = 9'd4;
    req_i = 4'b0001;
    tick();
    check("chg_grant", 32'(grant_o), 32'h1);
    tick();
    check("chg_done0", 32'(done_o), 32'h0);
    dl[0] = 9'd20;
    req_i = 4'b0000;
    tick();
    check("chg_done1", 32'(done_o), 32'h0);
    tick();
    check("chg_done2", 32'(done_o), 32'h0);
    tick();
    check("chg_done", 32'(done_o), 32'h1);
    check("chg_grant_hold", 32'(grant_o), 32'h1);
    tick();
    check("chg_idle", 32'(busy_o), 32'h0);

`ifdef DELAY_SCHED_CANCEL_EN
    // Cancel three cycles into a length-8 delay for requester 2
    apply_reset();
    dl[2] = 9'd8;
    dl[3] = 9'd2;
    req_i = 4'b1100;
    tick();
    check("cxl_grant", 32'(grant_o), 32'h4);
    tick();
    tick();
    tick();
    cancel_i = 1'b1;
    req_i    = 4'b1000;
    tick();
    cancel_i = 1'b0;
    check("cxl_grant_clr", 32'(grant_o), 32'h0);
    check("cxl_done", 32'(done_o), 32'h0);
    check("cxl_busy", 32'(busy_o), 32'h0);
    expect_grant(3, 2, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
